// File: rtl/dsm_pkg.sv
// Shared definitions for the DSM output-stream consumers: word format of the
// DSM input (4-bit integer, 16-bit fraction) and the averaging FSM states.
package dsm_pkg;

  localparam int DSM_INT_W  = 4;
  localparam int DSM_FRAC_W = 16;
  localparam int DSM_WORD_W = DSM_INT_W + DSM_FRAC_W;

  // One DSM input word: integer part above the binary point, fraction below.
  typedef struct packed {
    logic [DSM_INT_W-1:0]  int_part;
    logic [DSM_FRAC_W-1:0] frac_part;
  } dsm_word_t;

  // Averager control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    ACCUM = 2'd2
  } dsm_state_e;

endpackage

// File: rtl/dsm_win_accum.sv
// Window accumulator for the DSM averager: a LOG2_WIN-bit sample counter and a
// LOG2_WIN+4-bit running sum. tc_o flags the last sample of a window and sum_o
// is the window total including the sample currently on sample_i, so the
// caller can capture it on that same edge. The accumulator then restarts from
// zero, so the first sample of the next window is counted exactly once.
module dsm_win_accum #(
  parameter int LOG2_WIN = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run_i,
  input  logic [3:0]            sample_i,
  output logic                  tc_o,
  output logic [LOG2_WIN+3:0]   sum_o
);

  localparam int ACC_W = LOG2_WIN + 4;

  logic [LOG2_WIN-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;

  assign tc_o  = run_i && (cnt_q == '1);
  assign sum_o = acc_q + ACC_W'(sample_i);

  // Next-state: count and sum while running, clear whenever not running.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (!run_i) begin
      cnt_d = '0;
      acc_d = '0;
    end else begin
      cnt_d = cnt_q + LOG2_WIN'(1);
      acc_d = tc_o ? '0 : sum_o;
    end
  end

  // Counter and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/dsm_avg_decimator.sv
// Boxcar averager / decimator for the DSM 4-bit output stream. Averages over
// 2^LOG2_WIN cycles, discards SKIP_WIN settling windows after each enable rise,
// and presents each mean as a 4.16 word behind a one-deep valid/ready holder.
// Optional feature macro: DSM_AVG_ERR_EN adds exp_i/exp_f inputs and a signed
// avg_err output (window mean minus expected word), registered with the result.
module dsm_avg_decimator #(
  parameter int LOG2_WIN = 11,
  parameter int SKIP_WIN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  dsm_out,
  output logic [3:0]  avg_i,
  output logic [15:0] avg_f,
  output logic        avg_valid,
  input  logic        avg_ready,
  output logic        overrun,
  output logic        busy
`ifdef DSM_AVG_ERR_EN
  ,
  input  logic [3:0]  exp_i,
  input  logic [15:0] exp_f,
  output logic [20:0] avg_err
`endif
);

  import dsm_pkg::*;

  localparam logic [3:0] SKIP_LAST = (SKIP_WIN > 0) ? 4'(SKIP_WIN - 1) : 4'd0;

  // Window sum -> 4.16 word: top four bits are the integer mean, the remaining
  // LOG2_WIN bits are the fraction, left-aligned. Exact, no rounding.
  function automatic dsm_word_t fmt_window(input logic [LOG2_WIN+3:0] s);
    dsm_word_t w;
    w.int_part  = s[LOG2_WIN+3:LOG2_WIN];
    w.frac_part = DSM_FRAC_W'({s[LOG2_WIN-1:0], 16'h0000} >> LOG2_WIN);
    return w;
  endfunction

`ifdef DSM_AVG_ERR_EN
  // Signed difference of two unsigned 4.16 words in 21-bit two's complement.
  function automatic logic signed [DSM_WORD_W:0] word_err(input dsm_word_t a,
                                                          input dsm_word_t b);
    logic signed [DSM_WORD_W:0] sa;
    logic signed [DSM_WORD_W:0] sb;
    sa = $signed({1'b0, a});
    sb = $signed({1'b0, b});
    return sa - sb;
  endfunction
`endif

  dsm_state_e          state_q, state_d;
  logic [3:0]          skip_q, skip_d;
  dsm_word_t           res_q, res_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;

  logic                run;
  logic                win_tc;
  logic [LOG2_WIN+3:0] win_sum;
  logic                load;
  logic                accept;
  dsm_word_t           win_word;

  assign run      = en && (state_q != IDLE);
  assign load     = win_tc && (state_q == ACCUM);
  assign accept   = valid_q && avg_ready;
  assign win_word = fmt_window(win_sum);

  dsm_win_accum #(
    .LOG2_WIN (LOG2_WIN)
  ) u_accum (
    .clk      (clk),
    .rst      (rst),
    .run_i    (run),
    .sample_i (dsm_out),
    .tc_o     (win_tc),
    .sum_o    (win_sum)
  );

  // Control FSM: en low always returns to IDLE; SKIP counts settling windows.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    if (!en) begin
      state_d = IDLE;
      skip_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = (SKIP_WIN > 0) ? SKIP : ACCUM;
          skip_d  = '0;
        end
        SKIP: begin
          if (win_tc) begin
            if (skip_q == SKIP_LAST) begin
              state_d = ACCUM;
              skip_d  = '0;
            end else begin
              skip_d = skip_q + 4'd1;
            end
          end
        end
        ACCUM: begin
          state_d = ACCUM;
        end
        default: begin
          state_d = IDLE;
          skip_d  = '0;
        end
      endcase
    end
  end

  // Result holder: a completing window always loads; an unaccepted old result
  // being replaced marks the sticky overrun flag.
  always_comb begin
    res_d   = res_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (load) begin
      res_d   = win_word;
      valid_d = 1'b1;
      if (valid_q && !avg_ready) begin
        ovr_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  // State, result and handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      skip_q  <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef DSM_AVG_ERR_EN
  logic signed [DSM_WORD_W:0] err_q, err_d;
  dsm_word_t                  exp_word;

  assign exp_word.int_part  = exp_i;
  assign exp_word.frac_part = exp_f;

  // Error term follows the result: same load edge, same overwrite behaviour.
  always_comb begin
    err_d = err_q;
    if (load) begin
      err_d = word_err(win_word, exp_word);
    end
  end

  // Error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign avg_err = err_q;
`endif

  assign avg_i     = res_q.int_part;
  assign avg_f     = res_q.frac_part;
  assign avg_valid = valid_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dsm_avg_decimator.sv
// Scoreboard bench for dsm_avg_decimator with LOG2_WIN=4, SKIP_WIN=1.
// Stimulus drives 16-sample windows and queues the hand-computed mean for each
// window that should be delivered; a monitor pops and compares on every
// accepted result.
module tb_dsm_avg_decimator;

  localparam int LOG2_WIN = 4;
  localparam int SKIP_WIN = 1;
  localparam int WIN      = 16;
  localparam int NONE     = -1;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  dsm_out;
  logic [3:0]  avg_i;
  logic [15:0] avg_f;
  logic        avg_valid;
  logic        avg_ready;
  logic        overrun;
  logic        busy;
`ifdef DSM_AVG_ERR_EN
  logic [3:0]  exp_i = 4'd8;
  logic [15:0] exp_f = 16'h4000;
  logic [20:0] avg_err;
`endif

  typedef struct packed {
    logic [3:0]  i;
    logic [15:0] f;
    logic [20:0] e;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dsm_avg_decimator #(
    .LOG2_WIN (LOG2_WIN),
    .SKIP_WIN (SKIP_WIN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .dsm_out   (dsm_out),
    .avg_i     (avg_i),
    .avg_f     (avg_f),
    .avg_valid (avg_valid),
    .avg_ready (avg_ready),
    .overrun   (overrun),
    .busy      (busy)
`ifdef DSM_AVG_ERR_EN
    ,
    .exp_i     (exp_i),
    .exp_f     (exp_f),
    .avg_err   (avg_err)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue one expected result; the error term is relative to exp word 8.4000h.
  task automatic push(input logic [3:0] i, input logic [15:0] f);
    exp_t e;
    e.i = i;
    e.f = f;
    e.e = 21'({1'b0, i, f}) - 21'h084000;
    sb.push_back(e);
  endtask

  // One window: even slots a, odd slots b, last slot overridden -> sum = 8a+7b+last.
  task automatic window(input int a, input int b, input int last, input bit do_push,
                        input logic [3:0] ei, input logic [15:0] ef,
                        input int rdy_on, input int rdy_off);
    if (do_push) push(ei, ef);
    for (int k = 0; k < WIN; k++) begin
      if (k == rdy_on)  avg_ready = 1'b1;
      if (k == rdy_off) avg_ready = 1'b0;
      dsm_out = (k == WIN - 1) ? 4'(last) : ((k % 2 == 0) ? 4'(a) : 4'(b));
      tick();
    end
  endtask

  // Monitor: every accepted result must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && avg_valid === 1'b1 && avg_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_result: got avg_i=%0h avg_f=%0h expected no result", avg_i, avg_f);
        end else begin
          mon_e = sb.pop_front();
          chk("avg_i", 32'(avg_i), 32'(mon_e.i));
          chk("avg_f", 32'(avg_f), 32'(mon_e.f));
`ifdef DSM_AVG_ERR_EN
          chk("avg_err", 32'(avg_err), 32'(mon_e.e));
`endif
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    avg_ready = 1'b1;
    dsm_out   = 4'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_valid",   32'(avg_valid), 32'd0);
    chk("rst_avg_i",   32'(avg_i),     32'd0);
    chk("rst_avg_f",   32'(avg_f),     32'd0);
    chk("rst_overrun", 32'(overrun),   32'd0);
    chk("rst_busy",    32'(busy),      32'd0);

    // Enable: one settling window, then back-to-back delivered windows.
    en = 1'b1;
    tick();
    chk("busy_after_en", 32'(busy), 32'd1);
    window(8, 8, 8,    1'b0, 4'd0,  16'h0000, NONE, NONE);
    chk("no_result_in_skip", 32'(avg_valid), 32'd0);
    window(8, 8, 8,    1'b1, 4'd8,  16'h0000, NONE, NONE);
    window(8, 9, 9,    1'b1, 4'd8,  16'h8000, NONE, NONE);
    window(2, 3, 0,    1'b1, 4'd2,  16'h5000, NONE, NONE);
    window(0, 0, 1,    1'b1, 4'd0,  16'h1000, NONE, NONE);
    window(15, 15, 14, 1'b1, 4'd14, 16'hF000, NONE, NONE);
    window(15, 15, 15, 1'b1, 4'd15, 16'h0000, NONE, NONE);

    // Acceptance and new completion on the same edge.
    window(5, 6, 7,    1'b1, 4'd5,  16'h9000, NONE, 1);
    chk("held_valid", 32'(avg_valid), 32'd1);
    window(1, 0, 3,    1'b1, 4'd0,  16'hB000, 15, NONE);
    chk("same_edge_valid",   32'(avg_valid), 32'd1);
    chk("same_edge_overrun", 32'(overrun),   32'd0);

    // en dropped after 9 samples: partial window discarded, SKIP repeated.
    for (int k = 0; k < 9; k++) begin
      dsm_out = 4'd15;
      tick();
    end
    en = 1'b0;
    tick();
    chk("busy_after_drop", 32'(busy), 32'd0);
    repeat (2) tick();
    en = 1'b1;
    tick();
    window(15, 15, 15, 1'b0, 4'd0,  16'h0000, NONE, NONE);
    window(4, 4, 4,    1'b1, 4'd4,  16'h0000, NONE, NONE);

    // Overrun: consumer stalls across three completions.
    window(15, 15, 15, 1'b0, 4'd0,  16'h0000, NONE, 1);
    chk("ovr_first_valid",   32'(avg_valid), 32'd1);
    chk("ovr_first_overrun", 32'(overrun),   32'd0);
    window(15, 15, 15, 1'b0, 4'd0,  16'h0000, NONE, NONE);
    chk("ovr_second_overrun", 32'(overrun),   32'd1);
    chk("ovr_second_valid",   32'(avg_valid), 32'd1);
    window(15, 15, 14, 1'b1, 4'd14, 16'hF000, NONE, NONE);
    avg_ready = 1'b1;
    en        = 1'b0;
    repeat (3) tick();
    chk("ovr_sticky",        32'(overrun),   32'd1);
    chk("ovr_drained_valid", 32'(avg_valid), 32'd0);

    // rst on a terminal-count edge while a result is held and ready rises.
    en = 1'b1;
    tick();
    window(15, 15, 15, 1'b0, 4'd0,  16'h0000, NONE, NONE);
    window(3, 3, 3,    1'b0, 4'd0,  16'h0000, NONE, 0);
    chk("pre_rst_valid", 32'(avg_valid), 32'd1);
    for (int k = 0; k < WIN - 1; k++) begin
      dsm_out = 4'd9;
      tick();
    end
    dsm_out   = 4'd9;
    rst       = 1'b1;
    avg_ready = 1'b1;
    tick();
    chk("tc_rst_valid",   32'(avg_valid), 32'd0);
    chk("tc_rst_avg_i",   32'(avg_i),     32'd0);
    chk("tc_rst_avg_f",   32'(avg_f),     32'd0);
    chk("tc_rst_overrun", 32'(overrun),   32'd0);
    chk("tc_rst_busy",    32'(busy),      32'd0);
    rst = 1'b0;
    en  = 1'b0;
    repeat (3) tick();
    chk("post_rst_valid", 32'(avg_valid), 32'd0);

    // Normal operation after reset.
    en = 1'b1;
    tick();
    window(7, 7, 7,    1'b0, 4'd0,  16'h0000, NONE, NONE);
    window(0, 0, 1,    1'b1, 4'd0,  16'h1000, NONE, NONE);
    en = 1'b0;
    tick();

    for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
    n_chk++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
